// File: rtl/spi_pkg.sv
// Shared types for the SPI register-access path: arbiter FSM states and the
// engine command payload.
package spi_pkg;

    localparam int unsigned SPI_ADDR_W = 8;
    localparam int unsigned SPI_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                  wr;
        logic [SPI_ADDR_W-1:0] addr;
        logic [SPI_DATA_W-1:0] wdata;
    } spi_cmd_t;

endpackage

// File: rtl/spi_req_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after i_ptr,
// wrapping modulo N. Reusable for any shared resource.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_grant_idx,
    output logic          o_any
);

    logic [PW-1:0] w_j;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = |i_req;
        w_j         = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            w_j = PW'((int'(i_ptr) + k) % int'(N));
            if (i_req[w_j]) begin
                o_grant      = '0;
                o_grant[w_j] = 1'b1;
                o_grant_idx  = w_j;
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one SPI register-access engine between NUM_REQ requesters, one
// transaction outstanding, with round-robin grant and a response timeout.
module spi_req_arbiter
    import spi_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_wr,
    input  logic [NUM_REQ*SPI_ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*SPI_DATA_W-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [SPI_DATA_W-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             spi_cmd_valid,
    input  logic                             spi_cmd_ready,
    output logic                             spi_cmd_wr,
    output logic [SPI_ADDR_W-1:0]            spi_cmd_addr,
    output logic [SPI_DATA_W-1:0]            spi_cmd_wdata,
    input  logic                             spi_rsp_valid,
    input  logic [SPI_DATA_W-1:0]            spi_rsp_rdata
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    arb_state_t           r_state;
    logic [PW-1:0]        r_rr_ptr;
    logic [PW-1:0]        r_grant_idx;
    logic [NUM_REQ-1:0]   r_grant;
    logic [TW-1:0]        r_timer;
    spi_cmd_t             r_cmd;
    logic                 r_cmd_valid;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [SPI_DATA_W-1:0] r_rsp_rdata;
    logic                 r_rsp_err;

    logic [NUM_REQ-1:0]   w_grant;
    logic [PW-1:0]        w_grant_idx;
    logic                 w_any;
    spi_cmd_t             w_sel;
    logic [PW-1:0]        w_ptr_next;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr (
        .i_req       (req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    // Mux the granted requester's fields.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_grant[i]) begin
                w_sel.wr    = req_wr[i];
                w_sel.addr  = req_addr[i*SPI_ADDR_W +: SPI_ADDR_W];
                w_sel.wdata = req_wdata[i*SPI_DATA_W +: SPI_DATA_W];
            end
        end
    end

    assign w_ptr_next = (r_grant_idx == PW'(NUM_REQ - 1)) ? '0 : r_grant_idx + PW'(1);

    assign req_ready     = (r_state == ST_IDLE && !areset) ? w_grant : '0;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_err       = r_rsp_err;
    assign spi_cmd_valid = r_cmd_valid;
    assign spi_cmd_wr    = r_cmd.wr;
    assign spi_cmd_addr  = r_cmd.addr;
    assign spi_cmd_wdata = r_cmd.wdata;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_grant     <= '0;
            r_timer     <= '0;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_cmd       <= w_sel;
                        r_grant     <= w_grant;
                        r_grant_idx <= w_grant_idx;
                        r_cmd_valid <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (spi_cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_timer     <= '0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_timer <= r_timer + TW'(1);
                    // An engine response in the final cycle beats the timeout.
                    if (spi_rsp_valid) begin
                        r_rsp_rdata <= spi_rsp_rdata;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= r_grant;
                        r_state     <= ST_RESP;
                    end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= r_grant;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_rsp_valid <= '0;
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b0;
                    r_rr_ptr    <= w_ptr_next;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: vector table of single transactions plus
// round-robin, hold-off and reset-abort sequences.
module tb_spi_req_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 64;

    logic           aclk;
    logic           areset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_wr;
    logic [N*8-1:0] req_addr;
    logic [N*8-1:0] req_wdata;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rsp_rdata;
    logic           rsp_err;
    logic           spi_cmd_valid;
    logic           spi_cmd_ready;
    logic           spi_cmd_wr;
    logic [7:0]     spi_cmd_addr;
    logic [7:0]     spi_cmd_wdata;
    logic           spi_rsp_valid;
    logic [7:0]     spi_rsp_rdata;

    spi_req_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .spi_cmd_valid (spi_cmd_valid),
        .spi_cmd_ready (spi_cmd_ready),
        .spi_cmd_wr    (spi_cmd_wr),
        .spi_cmd_addr  (spi_cmd_addr),
        .spi_cmd_wdata (spi_cmd_wdata),
        .spi_rsp_valid (spi_rsp_valid),
        .spi_rsp_rdata (spi_rsp_rdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int         r;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         lat;      // engine response cycle within WAIT; 0 = never
        logic [7:0] erd;
        int         hold;     // cycles spi_cmd_ready is held low
        logic [3:0] exp_oh;
        logic [7:0] exp_rd;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_req(input int r, input logic wr, input logic [7:0] a, input logic [7:0] d);
        req_wr[r]          = wr;
        req_addr[r*8 +: 8]  = a;
        req_wdata[r*8 +: 8] = d;
    endtask

    // Engine pulse outside WAIT must be ignored.
    task automatic stray();
        spi_rsp_valid = 1'b1;
        spi_rsp_rdata = 8'hEE;
        tick();
        spi_rsp_valid = 1'b0;
        spi_rsp_rdata = 8'h00;
        chk("stray_rsp", {rsp_valid, rsp_rdata, rsp_err}, 32'h0);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        set_req(v.r, v.wr, v.addr, v.wdata);
        req_valid = 4'(1) << v.r;
        #1;
        chk("ready", req_ready, v.exp_oh);
        tick();
        req_valid = '0;
        chk("cmd", {spi_cmd_valid, spi_cmd_wr, spi_cmd_addr, spi_cmd_wdata},
            {1'b1, v.wr, v.addr, v.wdata});
        for (int h = 0; h < v.hold; h++) begin
            req_valid     = ~(4'(1) << v.r);
            spi_rsp_valid = (h == 5);
            tick();
            chk("hold_ready", req_ready, 4'b0000);
            chk("hold_cmd", {rsp_valid, spi_cmd_valid, spi_cmd_wr, spi_cmd_addr, spi_cmd_wdata},
                {4'b0000, 1'b1, v.wr, v.addr, v.wdata});
        end
        req_valid     = '0;
        spi_rsp_valid = 1'b0;
        spi_cmd_ready = 1'b1;
        tick();
        spi_cmd_ready = 1'b0;
        chk("hs_valid_low", spi_cmd_valid, 1'b0);
        n = 0;
        while (n < 200) begin
            if (v.lat > 0 && n == v.lat - 1) begin
                spi_rsp_valid = 1'b1;
                spi_rsp_rdata = v.erd;
            end
            tick();
            spi_rsp_valid = 1'b0;
            spi_rsp_rdata = 8'h00;
            n++;
            if (rsp_valid != '0) break;
        end
        chk("rsp_latency", n, v.exp_lat);
        chk("rsp_valid", rsp_valid, v.exp_oh);
        chk("rsp_rdata", rsp_rdata, v.exp_rd);
        chk("rsp_err", rsp_err, v.exp_err);
        tick();
        chk("rsp_clear", {rsp_valid, rsp_rdata, rsp_err}, 32'h0);
        stray();
    endtask

    vec_t tbl [6];

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_oh;
        int         n;

        tbl[0] = '{2, 1'b1, 8'h12, 8'hA5, 10, 8'h5A, 0,  4'b0100, 8'h5A, 1'b0, 10};
        tbl[1] = '{1, 1'b0, 8'h80, 8'h00, 3,  8'h3C, 0,  4'b0010, 8'h3C, 1'b0, 3};
        tbl[2] = '{3, 1'b0, 8'h7F, 8'h00, 1,  8'hFF, 0,  4'b1000, 8'hFF, 1'b0, 1};
        tbl[3] = '{0, 1'b1, 8'h00, 8'hFF, 64, 8'h81, 0,  4'b0001, 8'h81, 1'b0, 64};
        tbl[4] = '{2, 1'b0, 8'h44, 8'h00, 0,  8'h00, 0,  4'b0100, 8'h00, 1'b1, 64};
        tbl[5] = '{1, 1'b0, 8'h55, 8'h00, 5,  8'hC3, 20, 4'b0010, 8'hC3, 1'b0, 5};

        areset        = 1'b1;
        req_valid     = 4'hF;
        req_wr        = '0;
        req_addr      = '0;
        req_wdata     = '0;
        spi_cmd_ready = 1'b0;
        spi_rsp_valid = 1'b0;
        spi_rsp_rdata = 8'h00;
        tick();
        chk("ready_in_reset", req_ready, 4'b0000);
        req_valid = '0;
        tick();
        areset = 1'b0;
        #1;
        chk("reset_state", {req_ready, rsp_valid, rsp_rdata, rsp_err, spi_cmd_valid,
            spi_cmd_wr, spi_cmd_addr, spi_cmd_wdata}, 32'h0);

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // All four requesters held high from reset release.
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(8'h10 + i), 8'h00);
        req_valid = 4'hF;
        areset    = 1'b1;
        tick();
        areset        = 1'b0;
        spi_cmd_ready = 1'b1;
        #1;
        for (int g = 0; g < 6; g++) begin
            exp_oh = 4'(1) << (g % 4);
            n = 0;
            while (req_ready == '0 && n < 20) begin
                tick();
                n++;
            end
            chk("rr_grant", req_ready, exp_oh);
            tick();
            chk("rr_addr", spi_cmd_addr, 8'(8'h10 + (g % 4)));
            chk("rr_ready_issue", req_ready, 4'b0000);
            tick();
            chk("rr_ready_wait", req_ready, 4'b0000);
            spi_rsp_valid = 1'b1;
            spi_rsp_rdata = 8'(g);
            tick();
            spi_rsp_valid = 1'b0;
            chk("rr_rsp", {rsp_valid, rsp_rdata}, {exp_oh, 8'(g)});
            chk("rr_ready_resp", req_ready, 4'b0000);
            tick();
        end
        spi_cmd_ready = 1'b0;
        req_valid     = '0;
        tick();

        // Reset while waiting on the engine aborts the transaction.
        set_req(2, 1'b1, 8'h66, 8'h77);
        req_valid = 4'b0100;
        #1;
        chk("abort_grant", req_ready, 4'b0100);
        tick();
        req_valid     = '0;
        spi_cmd_ready = 1'b1;
        tick();
        spi_cmd_ready = 1'b0;
        tick();
        tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        chk("abort_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_err, spi_cmd_valid,
            spi_cmd_wr, spi_cmd_addr, spi_cmd_wdata}, 32'h0);
        spi_rsp_valid = 1'b1;
        spi_rsp_rdata = 8'h99;
        tick();
        spi_rsp_valid = 1'b0;
        spi_rsp_rdata = 8'h00;
        chk("abort_late_rsp", rsp_valid, 4'b0000);
        tick();
        chk("abort_late_rsp2", {rsp_valid, spi_cmd_valid}, 32'h0);
        req_valid = 4'b0101;
        #1;
        chk("post_reset_grant", req_ready, 4'b0001);
        req_valid = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
